gbn_receiver: RTL and testbench

- Receive-side endpoint of the LaserNet go-back-n link.
- Consumes decoded incoming packets (sequence number, flags, one payload word) and tracks the peer's handshake.
- Accepts only the in-order sequence number, writes accepted payload into the receive buffer, and requests an acknowledgment for every relevant packet (cumulative ACK, duplicate ACK on loss).
- Sits between the packet decoder and the transmit-side controller, which builds ACK packets from `ACKout`.

---
 rtl/gbn_receiver.sv | 147 ++++++++++++++
 tb/tb_gbn_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gbn_receiver.sv
// Go-back-n receive endpoint: in-order accept, cumulative/duplicate ACK requests; 1-cycle latency, no backpressure.
// Optional drop counter enabled by defining GBN_RX_DROPCOUNT_EN (otherwise dropcount is tied to zero).
module gbn_receiver #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rearm,
  input  logic              readyin,
  input  logic [31:0]       SEQin,
  input  logic [8:0]        flagsin,
  input  logic [DATA_W-1:0] datain,
  output logic              ackreq,
  output logic [31:0]       ACKout,
  output logic [31:0]       peerISN,
  output logic              FINreceived,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       rxcount,
  output logic [15:0]       dropcount,
  output logic [1:0]        statedisplay
);

  typedef enum logic [1:0] {
    S_LISTEN  = 2'd0,
    S_SYNRCVD = 2'd1,
    S_ESTAB   = 2'd2,
    S_CLOSED  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_ackreq;
  logic [31:0]       r_ack;
  logic [31:0]       r_peer_isn;
  logic              r_fin;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [31:0]       r_rxcount;

  logic        w_syn;
  logic        w_fin;
  logic        w_in_order;
  logic [31:0] w_offset;
  logic        w_unused;

  assign w_syn      = flagsin[1];
  assign w_fin      = flagsin[0];
  assign w_in_order = (SEQin == r_ack);
  // Buffer slot is the payload index relative to the first data sequence number.
  assign w_offset   = SEQin - r_peer_isn - 32'd1;
  assign w_unused   = ^{flagsin[8:5], flagsin[3:2], w_offset[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LISTEN;
      r_ackreq   <= 1'b0;
      r_ack      <= 32'd0;
      r_peer_isn <= 32'd0;
      r_fin      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rxcount  <= 32'd0;
    end else begin
      r_ackreq <= 1'b0;
      r_wr_en  <= 1'b0;
      if (rearm && r_state == S_CLOSED) begin
        r_state    <= S_LISTEN;
        r_ack      <= 32'd0;
        r_peer_isn <= 32'd0;
        r_fin      <= 1'b0;
        r_rxcount  <= 32'd0;
      end else if (readyin) begin
        case (r_state)
          S_LISTEN: begin
            if (w_syn) begin
              r_peer_isn <= SEQin;
              r_ack      <= SEQin + 32'd1;
              r_ackreq   <= 1'b1;
              r_state    <= S_SYNRCVD;
            end
          end
          S_SYNRCVD, S_ESTAB: begin
            if (w_syn) begin
              r_ackreq <= 1'b1;
            end else if (w_in_order && !w_fin) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_offset[ADDR_W-1:0];
              r_wr_data <= datain;
              r_ack     <= r_ack + 32'd1;
              r_rxcount <= r_rxcount + 32'd1;
              r_ackreq  <= 1'b1;
              r_state   <= S_ESTAB;
            end else if (w_in_order) begin
              r_ack    <= r_ack + 32'd1;
              r_fin    <= 1'b1;
              r_ackreq <= 1'b1;
              r_state  <= S_CLOSED;
            end else begin
              // Duplicate ACK of the unchanged expected number triggers the sender's resend.
              r_ackreq <= 1'b1;
            end
          end
          S_CLOSED: begin
            if (w_fin && SEQin == r_ack - 32'd1) begin
              r_ackreq <= 1'b1;
            end
          end
          default: r_state <= S_LISTEN;
        endcase
      end
    end
  end

`ifdef GBN_RX_DROPCOUNT_EN
  logic [15:0] r_dropcount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropcount <= 16'd0;
    end else if (rearm && r_state == S_CLOSED) begin
      r_dropcount <= 16'd0;
    end else if (readyin && (r_state == S_SYNRCVD || r_state == S_ESTAB)
                 && !w_syn && !w_in_order && r_dropcount != 16'hFFFF) begin
      r_dropcount <= r_dropcount + 16'd1;
    end
  end

  assign dropcount = r_dropcount;
`else
  assign dropcount = 16'd0;
`endif

  assign ackreq       = r_ackreq;
  assign ACKout       = r_ack;
  assign peerISN      = r_peer_isn;
  assign FINreceived  = r_fin;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign rxcount      = r_rxcount;
  assign statedisplay = r_state;

endmodule

// File: tb/tb_gbn_receiver.sv
// Directed bench for gbn_receiver: handshake, data, loss, close, rearm, wrap and reset.
module tb_gbn_receiver;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
`ifdef GBN_RX_DROPCOUNT_EN
  localparam logic [31:0] DROP1 = 32'd1;
`else
  localparam logic [31:0] DROP1 = 32'd0;
`endif
  localparam logic [8:0] F_NONE = 9'h000;
  localparam logic [8:0] F_SYN  = 9'h002;
  localparam logic [8:0] F_FIN  = 9'h011;
  localparam logic [8:0] F_ACK  = 9'h010;

  logic              clk = 1'b0;
  logic              reset;
  logic              rearm;
  logic              readyin;
  logic [31:0]       SEQin;
  logic [8:0]        flagsin;
  logic [DATA_W-1:0] datain;
  logic              ackreq;
  logic [31:0]       ACKout;
  logic [31:0]       peerISN;
  logic              FINreceived;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       rxcount;
  logic [15:0]       dropcount;
  logic [1:0]        statedisplay;

  int n_checks = 0;
  int n_errors = 0;

  gbn_receiver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rearm(rearm), .readyin(readyin),
    .SEQin(SEQin), .flagsin(flagsin), .datain(datain),
    .ackreq(ackreq), .ACKout(ACKout), .peerISN(peerISN),
    .FINreceived(FINreceived), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rxcount(rxcount), .dropcount(dropcount),
    .statedisplay(statedisplay)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one packet for a single cycle; returns at the following negedge with results visible.
  task automatic send(input logic [31:0] seq, input logic [8:0] fl, input logic [15:0] d);
    readyin = 1'b1; SEQin = seq; flagsin = fl; datain = d;
    @(negedge clk);
    readyin = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rearm = 1'b0; readyin = 1'b0;
    SEQin = 32'd0; flagsin = F_NONE; datain = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", {30'd0, statedisplay}, 32'd0);
    chk("rst_ack", ACKout, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_ackreq", {31'd0, ackreq}, 32'd0);

    // Non-SYN in LISTEN is ignored
    send(32'h50, F_ACK, 16'h1234);
    chk("listen_ign_ackreq", {31'd0, ackreq}, 32'd0);
    chk("listen_ign_state", {30'd0, statedisplay}, 32'd0);

    // Handshake
    send(32'h100, F_SYN, 16'h0);
    chk("hs_ackreq", {31'd0, ackreq}, 32'd1);
    chk("hs_isn", peerISN, 32'h100);
    chk("hs_ack", ACKout, 32'h101);
    chk("hs_state", {30'd0, statedisplay}, 32'd1);

    // Retransmitted SYN
    send(32'h100, F_SYN, 16'h0);
    chk("resyn_ackreq", {31'd0, ackreq}, 32'd1);
    chk("resyn_ack", ACKout, 32'h101);
    chk("resyn_state", {30'd0, statedisplay}, 32'd1);

    // Back-to-back in-order data
    send(32'h101, F_NONE, 16'hAAAA);
    chk("d0_wr_en", {31'd0, wr_en}, 32'd1);
    chk("d0_addr", {22'd0, wr_addr}, 32'd0);
    chk("d0_data", {16'd0, wr_data}, 32'hAAAA);
    send(32'h102, F_NONE, 16'hBBBB);
    chk("d1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("d1_addr", {22'd0, wr_addr}, 32'd1);
    chk("d1_data", {16'd0, wr_data}, 32'hBBBB);
    chk("d1_ack", ACKout, 32'h103);
    chk("d1_rxcount", rxcount, 32'd2);
    chk("d1_state", {30'd0, statedisplay}, 32'd2);
    @(negedge clk);
    chk("pulse_wr_en", {31'd0, wr_en}, 32'd0);
    chk("pulse_ackreq", {31'd0, ackreq}, 32'd0);

    // Loss then resend
    send(32'h105, F_NONE, 16'hCCCC);
    chk("loss_wr_en", {31'd0, wr_en}, 32'd0);
    chk("loss_ackreq", {31'd0, ackreq}, 32'd1);
    chk("loss_ack", ACKout, 32'h103);
    chk("loss_drop", {16'd0, dropcount}, DROP1);
    send(32'h103, F_NONE, 16'hDDDD);
    chk("resend_wr_en", {31'd0, wr_en}, 32'd1);
    chk("resend_addr", {22'd0, wr_addr}, 32'd2);
    chk("resend_data", {16'd0, wr_data}, 32'hDDDD);
    chk("resend_ack", ACKout, 32'h104);
    chk("resend_rx", rxcount, 32'd3);

    // Close
    send(32'h104, F_FIN, 16'h0);
    chk("fin_wr_en", {31'd0, wr_en}, 32'd0);
    chk("fin_flag", {31'd0, FINreceived}, 32'd1);
    chk("fin_ack", ACKout, 32'h105);
    chk("fin_state", {30'd0, statedisplay}, 32'd3);
    chk("fin_ackreq", {31'd0, ackreq}, 32'd1);
    send(32'h104, F_FIN, 16'h0);
    chk("refin_ackreq", {31'd0, ackreq}, 32'd1);
    chk("refin_ack", ACKout, 32'h105);
    send(32'h105, F_NONE, 16'h0);
    chk("closed_ign_ackreq", {31'd0, ackreq}, 32'd0);
    chk("closed_ign_wr_en", {31'd0, wr_en}, 32'd0);

    // Rearm with a coincident packet: rearm wins
    rearm = 1'b1;
    send(32'h104, F_FIN, 16'h0);
    rearm = 1'b0;
    chk("rearm_ackreq", {31'd0, ackreq}, 32'd0);
    chk("rearm_state", {30'd0, statedisplay}, 32'd0);
    chk("rearm_ack", ACKout, 32'd0);
    chk("rearm_isn", peerISN, 32'd0);
    chk("rearm_fin", {31'd0, FINreceived}, 32'd0);
    chk("rearm_rx", rxcount, 32'd0);
    chk("rearm_drop", {16'd0, dropcount}, 32'd0);

    // Sequence wrap
    send(32'hFFFF_FFFE, F_SYN, 16'h0);
    chk("wrap_ack0", ACKout, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, F_NONE, 16'h1111);
    chk("wrap_d0_wr_en", {31'd0, wr_en}, 32'd1);
    chk("wrap_d0_addr", {22'd0, wr_addr}, 32'd0);
    chk("wrap_d0_ack", ACKout, 32'd0);
    send(32'h0000_0000, F_NONE, 16'h2222);
    chk("wrap_d1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("wrap_d1_addr", {22'd0, wr_addr}, 32'd1);
    chk("wrap_d1_data", {16'd0, wr_data}, 32'h2222);
    chk("wrap_d1_ack", ACKout, 32'd1);

    // rearm outside CLOSED is ignored
    pulse_rearm();
    chk("rearm_ign_state", {30'd0, statedisplay}, 32'd2);
    chk("rearm_ign_ack", ACKout, 32'd1);

    // Reset mid-stream with a valid in-order packet present
    reset = 1'b1;
    send(32'd1, F_NONE, 16'h3333);
    reset = 1'b0;
    chk("mrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mrst_ackreq", {31'd0, ackreq}, 32'd0);
    chk("mrst_ack", ACKout, 32'd0);
    chk("mrst_isn", peerISN, 32'd0);
    chk("mrst_rx", rxcount, 32'd0);
    chk("mrst_addr", {22'd0, wr_addr}, 32'd0);
    chk("mrst_data", {16'd0, wr_data}, 32'd0);
    chk("mrst_state", {30'd0, statedisplay}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
